mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data-path width in bits; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter TMO_CYCLES, default 255, maximum cycles spent waiting for mem_ack before a timeout fault; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  pipeline offers an access this cycle.
REQ-007 req_rd / req_wr  input  1 each  load / store request.
REQ-008 req_size  input  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-009 req_unsigned  input  1  load result is zero-extended instead of sign-extended.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 st_data / wb_data  input  DATA_W  register store operand / write-back forwarding operand.
REQ-012 fwd_sel  input  1  1 selects wb_data as the store operand.
REQ-013 busy  output  1  stall request to the pipeline.
REQ-014 ld_valid  output  1  one-cycle pulse when ld_data is valid.
REQ-015 ld_data  output  DATA_W  extended load result.
REQ-016 fault / fault_code  output  1 / 2  one-cycle fault pulse; code 1 misaligned, 2 illegal, 3 timeout.
REQ-017 mem_req, mem_we  output  1 each  bus request and write strobe.
REQ-018 mem_addr  output  ADDR_W  size-aligned address.
REQ-019 mem_be  output  DATA_W/8  byte enables; bit DATA_W/8-1 is the lane at offset 0 (big-endian).
REQ-020 mem_wdata  output  DATA_W  write data.
REQ-021 mem_ack, mem_rdata  input  1 / DATA_W  bus completion and read data.

Function
REQ-022 State machine: IDLE, BUS, RESP, FLT.
REQ-023 A request is accepted in IDLE when req_valid=1; all request fields are registered at acceptance.
REQ-024 The request is illegal when req_rd equals req_wr, or when req_size=3 with DATA_W=32; an illegal request enters FLT with code 2.
REQ-025 The request is misaligned when req_addr modulo (1<<req_size) is nonzero; a misaligned request enters FLT with code 1.
REQ-026 Faulting requests issue no bus access.
REQ-027 A legal request enters BUS, and mem_req rises on the cycle after acceptance.
REQ-028 mem_be = ((1<<(1<<size))-1) shifted toward the LSB by the lane offset, using the big-endian convention of REQ-019.
REQ-029 mem_wdata replicates the low (8<<size) bits of the selected store operand across all lanes.
REQ-030 mem_req, mem_we, mem_addr, mem_be and mem_wdata hold stable from BUS entry until mem_ack is sampled high.
REQ-031 mem_ack sampled in BUS causes mem_rdata to be captured and the state to move to RESP; mem_ack outside BUS is ignored.
REQ-032 RESP lasts exactly one cycle, then returns to IDLE.
REQ-033 For loads, ld_valid=1 in RESP, with ld_data holding the selected lanes right-justified and sign- or zero-extended to DATA_W.
REQ-034 For stores, ld_valid stays 0 and RESP lasts exactly one cycle.
REQ-035 A 16-bit wait counter clears on BUS entry and increments each BUS cycle without mem_ack.
REQ-036 When the wait counter reaches TMO_CYCLES, mem_req drops and the state enters FLT with code 3.
REQ-037 FLT lasts exactly one cycle with fault=1, then returns to IDLE.
REQ-038 busy = (state != IDLE) OR (req_valid in IDLE); busy deasserts on the cycle the state returns to IDLE.
REQ-039 Minimum load latency is acceptance N, mem_ack at N+1, ld_valid at N+2.

Reset
REQ-040 On rst=0, independent of clk: state IDLE; mem_req, mem_we, mem_be, ld_valid, fault, busy, fault_code, ld_data, mem_wdata and mem_addr all 0; wait counter cleared.
REQ-041 A reset asserted during BUS aborts the access with no completion or fault pulse.

Structure
REQ-042 Size encodings, fault codes and state encodings reside in the shared definitions package.
REQ-043 Lane-select and extension logic SHALL be one sub-module, lane_extract, instantiated for the load path.

Verification
REQ-044 DATA_W=32: lb at addr 0x3, mem_rdata=0x000000F0, ack at N+1 -> ld_valid at N+2, ld_data=0xFFFFFFF0, mem_be=0001.
REQ-045 sh, addr 0x2, fwd_sel=1, wb_data=0x0000ABCD -> mem_be=0011, mem_wdata=0xABCDABCD, mem_we=1, no ld_valid.
REQ-046 lw at addr 0x6 -> fault=1, code 1, mem_req never asserted, busy for exactly 2 cycles.
REQ-047 TMO_CYCLES=4, lw with no ack -> mem_req high 4 cycles, then fault code 3, then IDLE.
REQ-048 lhu at 0x0, rst pulsed low mid-BUS, then ack -> all outputs 0 and no ld_valid.
REQ-049 DATA_W=64: ld (size 3) at 0x8 -> mem_be=0xFF; DATA_W=32 with size 3 -> fault code 2.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store access controller: access sizes,
// fault codes and controller states.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_ILLEGAL  = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_FLT  = 2'd3
  } state_e;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/lane_extract.sv
// Picks the addressed byte lanes out of a big-endian bus word, right-justifies
// them and sign- or zero-extends the result to the full data width.
module lane_extract
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  lane,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  localparam int NB = DATA_W / 8;

  always_comb begin : extract
    int                nb;
    int                sh;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] sign_bit;
    // NOTE: combinational logic uses blocking '=' and assigns every variable
    // before any branch, so no latch can be inferred.
    nb = size_bytes(size);
    if (nb > NB) nb = NB;
    // Lane 0 sits in the top byte, so the field's LSB is below (NB-lane-nb) lanes.
    sh = 8 * (NB - nb - int'(lane));
    if (sh < 0) sh = 0;
    shifted  = rdata >> sh;
    mask     = (nb == NB) ? '1 : ((DATA_W'(1) << (8 * nb)) - DATA_W'(1));
    sign_bit = DATA_W'(1) << (8 * nb - 1);
    data     = shifted & mask;
    if (!is_unsigned && ((shifted & sign_bit) != '0)) data = data | ~mask;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller: validates a pipeline request,
// drives one big-endian bus access with timeout, and returns extended loads.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_rd,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                fwd_sel,
  output logic                busy,
  output logic                ld_valid,
  output logic [DATA_W-1:0]   ld_data,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e            state;
  logic [15:0]       wait_cnt;
  logic              r_rd;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [OFF_W-1:0]  r_lane;
  logic [DATA_W-1:0] ext_data;

  logic              illegal;
  logic              misaligned;
  logic [ADDR_W-1:0] aligned_addr;
  logic [NB-1:0]     be_c;
  logic [DATA_W-1:0] wdata_c;

  always_comb begin : decode
    int                nb;
    int                sh;
    logic [DATA_W-1:0] op;
    nb           = size_bytes(req_size);
    illegal      = (req_rd == req_wr) || (req_size == SZ_DWORD && DATA_W == 32);
    misaligned   = (req_addr & ADDR_W'(nb - 1)) != '0;
    aligned_addr = req_addr & ~ADDR_W'(nb - 1);
    sh           = NB - nb - int'(req_addr[OFF_W-1:0]);
    be_c         = '0;
    if (nb <= NB && sh >= 0) be_c = NB'(((1 << nb) - 1) << sh);
    op = fwd_sel ? wb_data : st_data;
    case (req_size)
      SZ_BYTE: wdata_c = {(DATA_W / 8){op[7:0]}};
      SZ_HALF: wdata_c = {(DATA_W / 16){op[15:0]}};
      SZ_WORD: wdata_c = {(DATA_W / 32){op[31:0]}};
      default: wdata_c = op;
    endcase
  end

  lane_extract #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_lane_extract (
    .rdata       (mem_rdata),
    .size        (r_size),
    .lane        (r_lane),
    .is_unsigned (r_unsigned),
    .data        (ext_data)
  );

  // Gated by reset so the stall request is low while the block is held in reset.
  assign busy = rst && ((state != ST_IDLE) || req_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      r_rd       <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_lane     <= '0;
      ld_valid   <= 1'b0;
      ld_data    <= '0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      // NOTE: state registers use non-blocking '<=' so every flop samples
      // pre-edge values regardless of statement order.
      ld_valid <= 1'b0;
      fault    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_rd       <= req_rd;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[OFF_W-1:0];
            if (illegal) begin
              state      <= ST_FLT;
              fault      <= 1'b1;
              fault_code <= FC_ILLEGAL;
            end else if (misaligned) begin
              state      <= ST_FLT;
              fault      <= 1'b1;
              fault_code <= FC_MISALIGN;
            end else begin
              state     <= ST_BUS;
              wait_cnt  <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_wr;
              mem_addr  <= aligned_addr;
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
            end
          end
        end
        ST_BUS: begin
          if (mem_ack) begin
            state    <= ST_RESP;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            ld_valid <= r_rd;
            if (r_rd) ld_data <= ext_data;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            // The count reaches TMO_CYCLES on this edge: mem_req was high TMO_CYCLES cycles.
            if (wait_cnt == 16'(TMO_CYCLES - 1)) begin
              state      <= ST_FLT;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              fault      <= 1'b1;
              fault_code <= FC_TIMEOUT;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_FLT:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
